// File: rtl/pairing_io_loader.sv
// Host-side loader for the pairing core: fans one host word out to the
// enabled RAM banks in redundant-limb form, and streams result words back
// from the readout port as a valid/ready burst.
module pairing_io_loader #(
  parameter int unsigned WORD_W     = 320,
  parameter int unsigned LIMB_W     = 64,
  parameter int unsigned CARRY_W    = 3,
  parameter int unsigned N_LIMB     = 5,
  parameter int unsigned N_BANK     = 4,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned BANK_SHIFT = 7,
  parameter int unsigned OUT_W      = 289,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_write,
  input  logic [ADDR_W-1:0]                    cmd_addr,
  input  logic [7:0]                           cmd_len,
  input  logic [N_BANK-1:0]                    cmd_bank_mask,
  input  logic [WORD_W-1:0]                    cmd_wdata,
  input  logic                                 core_busy,
  output logic                                 ext_en,
  output logic [ADDR_W-1:0]                    ext_addr,
  output logic [N_LIMB*(LIMB_W+CARRY_W)-1:0]   ext_data,
  output logic [ADDR_W-1:0]                    rd_addr,
  input  logic [OUT_W-1:0]                     rd_data,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [OUT_W-1:0]                     rsp_data,
  output logic                                 rsp_last,
  output logic                                 err
);

  localparam int unsigned SLOT_W = LIMB_W + CARRY_W;
  localparam int unsigned EXT_W  = N_LIMB * SLOT_W;
  localparam int unsigned PAD_W  = N_LIMB * LIMB_W;
  localparam int unsigned BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int unsigned WAIT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_RSP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [N_BANK-1:0]   mask_q, mask_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          word_q, word_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                ext_en_d;
  logic [ADDR_W-1:0]   ext_addr_d;
  logic [EXT_W-1:0]    ext_data_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic                rsp_valid_d;
  logic [OUT_W-1:0]    rsp_data_d;
  logic                rsp_last_d;
  logic                err_d;

  logic                accept;
  logic [PAD_W-1:0]    wpad;
  logic [EXT_W-1:0]    wfmt;
  logic [N_BANK-1:0]   scan_mask;
  logic [N_BANK-1:0]   scan_next;
  logic [ADDR_W-1:0]   scan_base;
  logic [BANK_W-1:0]   scan_idx;
  logic [ADDR_W-1:0]   bank_addr;

  assign cmd_ready = (state_q == IDLE) && !core_busy;
  assign accept    = cmd_valid && cmd_ready;

  // Split the host word into limbs with zero carries.
  always_comb begin
    wpad = PAD_W'(cmd_wdata);
    wfmt = '0;
    for (int unsigned i = 0; i < N_LIMB; i++) begin
      wfmt[i*SLOT_W +: SLOT_W] = {{CARRY_W{1'b0}}, wpad[i*LIMB_W +: LIMB_W]};
    end
  end

  // Lowest pending bank and its RAM address; IDLE looks at the incoming command.
  always_comb begin
    scan_mask = (state_q == IDLE) ? cmd_bank_mask : mask_q;
    scan_base = (state_q == IDLE) ? cmd_addr : addr_q;
    scan_next = scan_mask & (scan_mask - N_BANK'(1));
    scan_idx  = '0;
    for (int i = int'(N_BANK) - 1; i >= 0; i--) begin
      if (scan_mask[i]) scan_idx = BANK_W'(i);
    end
    bank_addr = scan_base + (ADDR_W'(scan_idx) << BANK_SHIFT);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    len_d       = len_q;
    word_d      = word_q;
    wait_d      = wait_q;
    ext_en_d    = 1'b0;
    ext_addr_d  = ext_addr;
    ext_data_d  = ext_data;
    rd_addr_d   = rd_addr;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_last_d  = rsp_last;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_write) begin
            if (cmd_bank_mask == '0) begin
              err_d = 1'b1;
            end else begin
              addr_d     = cmd_addr;
              mask_d     = scan_next;
              ext_en_d   = 1'b1;
              ext_addr_d = bank_addr;
              ext_data_d = wfmt;
              state_d    = WR;
            end
          end else begin
            rd_addr_d = cmd_addr;
            len_d     = cmd_len;
            word_d    = '0;
            wait_d    = WAIT_W'(RD_LAT);
            state_d   = RD_WAIT;
          end
        end
      end

      WR: begin
        if (mask_q != '0) begin
          ext_en_d   = 1'b1;
          ext_addr_d = bank_addr;
          mask_d     = scan_next;
        end else begin
          state_d = IDLE;
        end
      end

      RD_WAIT: begin
        if (wait_q <= WAIT_W'(1)) begin
          rsp_data_d  = rd_data;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (word_q == len_q);
          state_d     = RD_RSP;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      RD_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (word_q == len_q) begin
            state_d = IDLE;
          end else begin
            word_d    = word_q + 8'd1;
            rd_addr_d = rd_addr + ADDR_W'(1);
            wait_d    = WAIT_W'(RD_LAT);
            state_d   = RD_WAIT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      len_q     <= '0;
      word_q    <= '0;
      wait_q    <= '0;
      ext_en    <= 1'b0;
      ext_addr  <= '0;
      ext_data  <= '0;
      rd_addr   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      len_q     <= len_d;
      word_q    <= word_d;
      wait_q    <= wait_d;
      ext_en    <= ext_en_d;
      ext_addr  <= ext_addr_d;
      ext_data  <= ext_data_d;
      rd_addr   <= rd_addr_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_last  <= rsp_last_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_pairing_io_loader.sv
// Scoreboard bench for pairing_io_loader: directed cases plus a random
// command mix against a reference RAM and a bank/limb expansion model.
module tb_pairing_io_loader;

  localparam int unsigned WORD_W     = 320;
  localparam int unsigned LIMB_W     = 64;
  localparam int unsigned CARRY_W    = 3;
  localparam int unsigned N_LIMB     = 5;
  localparam int unsigned N_BANK     = 4;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned BANK_SHIFT = 7;
  localparam int unsigned OUT_W      = 289;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned EXT_W      = N_LIMB * (LIMB_W + CARRY_W);
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam int unsigned CW         = 512;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [EXT_W-1:0]  data;
  } wr_exp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  data;
    logic              last;
  } rsp_exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write, core_busy;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [N_BANK-1:0] cmd_bank_mask;
  logic [WORD_W-1:0] cmd_wdata;
  logic              ext_en;
  logic [ADDR_W-1:0] ext_addr;
  logic [EXT_W-1:0]  ext_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [OUT_W-1:0]  rd_data;
  logic              rsp_valid, rsp_ready, rsp_last, err;
  logic [OUT_W-1:0]  rsp_data;

  int checks = 0;
  int errors = 0;
  int rsp_pops = 0;
  bit rand_ready = 1'b0;

  wr_exp_t  exp_wr[$];
  rsp_exp_t exp_rsp[$];

  logic [OUT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr_q;

  always #5 clk = ~clk;

  pairing_io_loader #(
    .WORD_W(WORD_W), .LIMB_W(LIMB_W), .CARRY_W(CARRY_W), .N_LIMB(N_LIMB),
    .N_BANK(N_BANK), .ADDR_W(ADDR_W), .BANK_SHIFT(BANK_SHIFT),
    .OUT_W(OUT_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_bank_mask(cmd_bank_mask), .cmd_wdata(cmd_wdata),
    .core_busy(core_busy), .ext_en(ext_en), .ext_addr(ext_addr),
    .ext_data(ext_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .err(err)
  );

  // Readout RAM: one register stage plus combinational read gives RD_LAT = 2.
  initial forever begin
    @(posedge clk);
    rd_addr_q <= rd_addr;
  end
  assign rd_data = mem[rd_addr_q];

  task automatic chk(input bit ok, input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EXT_W-1:0] fmt(input logic [WORD_W-1:0] w);
    logic [EXT_W-1:0] r = '0;
    logic [EXT_W-1:0] limb;
    for (int i = 0; i < int'(N_LIMB); i++) begin
      limb = EXT_W'(w >> (i * LIMB_W));
      limb = limb & EXT_W'({LIMB_W{1'b1}});
      r = r | (limb << (i * (LIMB_W + CARRY_W)));
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] r = '0;
    for (int i = 0; i < int'((WORD_W + 31) / 32); i++) r = (r << 32) | WORD_W'($urandom);
    return r;
  endfunction

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [N_BANK-1:0] m, input logic [WORD_W-1:0] w);
    wr_exp_t e;
    for (int b = 0; b < int'(N_BANK); b++) begin
      if (m[b]) begin
        e.addr = ADDR_W'((int'(a) + b * (1 << BANK_SHIFT)) % int'(DEPTH));
        e.data = fmt(w);
        exp_wr.push_back(e);
      end
    end
  endtask

  task automatic push_rd(input logic [ADDR_W-1:0] a, input logic [7:0] len);
    rsp_exp_t e;
    for (int k = 0; k <= int'(len); k++) begin
      e.addr = ADDR_W'((int'(a) + k) % int'(DEPTH));
      e.data = mem[e.addr];
      e.last = (k == int'(len));
      exp_rsp.push_back(e);
    end
  endtask

  // Present a command and hold it until accepted; returns just after the accept edge.
  task automatic send(input bit wr, input logic [ADDR_W-1:0] a, input logic [7:0] len,
                      input logic [N_BANK-1:0] m, input logic [WORD_W-1:0] w, input bit push);
    int n = 0;
    @(posedge clk); #1;
    cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_bank_mask = m; cmd_wdata = w;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 2000);
    chk(cmd_ready, "accept_timeout", CW'(cmd_ready), CW'(1));
    if (push) begin
      if (wr) push_wr(a, m, w);
      else push_rd(a, len);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [N_BANK-1:0] m,
                          input logic [WORD_W-1:0] w, input bit busy_mid);
    send(1'b1, a, 8'd0, m, w, 1'b1);
    if (busy_mid) core_busy = 1'b1;
    if (m == '0) begin
      @(negedge clk);
      chk(err == 1'b1, "err_pulse", CW'(err), CW'(1));
      chk(ext_en == 1'b0, "err_no_write", CW'(ext_en), CW'(0));
      chk(cmd_ready == !core_busy, "err_stays_idle", CW'(cmd_ready), CW'(!core_busy));
      @(negedge clk);
      chk(err == 1'b0, "err_one_cycle", CW'(err), CW'(0));
    end else begin
      for (int k = 0; k < $countones(m); k++) begin
        @(negedge clk);
        chk(ext_en == 1'b1, "ext_en_run", CW'(ext_en), CW'(1));
      end
      @(negedge clk);
      chk(ext_en == 1'b0, "ext_en_end", CW'(ext_en), CW'(0));
      chk(cmd_ready == !core_busy, "ready_after_wr", CW'(cmd_ready), CW'(!core_busy));
    end
    chk(exp_wr.size() == 0, "writes_missing", CW'(exp_wr.size()), CW'(0));
    core_busy = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [7:0] len, input bit busy_mid);
    int n = 0;
    send(1'b0, a, len, '0, '0, 1'b1);
    if (busy_mid) core_busy = 1'b1;
    @(negedge clk);
    chk(rd_addr == a, "rd_addr_start", CW'(rd_addr), CW'(a));
    while (exp_rsp.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(exp_rsp.size() == 0, "rsp_timeout", CW'(exp_rsp.size()), CW'(0));
    @(negedge clk);
    chk(rsp_valid == 1'b0, "rsp_idle", CW'(rsp_valid), CW'(0));
    chk(cmd_ready == !core_busy, "ready_after_rd", CW'(cmd_ready), CW'(!core_busy));
    core_busy = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk(cmd_ready == 1'b1, "rst_cmd_ready", CW'(cmd_ready), CW'(1));
    chk(ext_en == 1'b0 && ext_addr == '0, "rst_ext", CW'({ext_en, ext_addr}), CW'(0));
    chk(ext_data == '0, "rst_ext_data", CW'(ext_data), CW'(0));
    chk(rd_addr == '0, "rst_rd_addr", CW'(rd_addr), CW'(0));
    chk(rsp_valid == 1'b0 && rsp_last == 1'b0 && err == 1'b0, "rst_flags",
        CW'({rsp_valid, rsp_last, err}), CW'(0));
    chk(rsp_data == '0, "rst_rsp_data", CW'(rsp_data), CW'(0));
  endtask

  // Monitor: scores RAM writes and response handshakes, and checks stall stability.
  initial begin
    bit prev_stall = 1'b0;
    bit prev_rst = 1'b1;
    logic [OUT_W-1:0] prev_data = '0;
    wr_exp_t  we;
    rsp_exp_t re;
    forever begin
      @(negedge clk);
      if (ext_en) begin
        chk(exp_wr.size() != 0, "write_expected", CW'(ext_addr), CW'(0));
        if (exp_wr.size() != 0) begin
          we = exp_wr.pop_front();
          chk(ext_addr == we.addr, "ext_addr", CW'(ext_addr), CW'(we.addr));
          chk(ext_data == we.data, "ext_data", CW'(ext_data), CW'(we.data));
        end
      end
      if (prev_stall && !prev_rst) begin
        chk(rsp_valid == 1'b1 && rsp_data == prev_data, "rsp_stable", CW'(rsp_data), CW'(prev_data));
      end
      if (rsp_valid && rsp_ready) begin
        chk(exp_rsp.size() != 0, "rsp_expected", CW'(rsp_data), CW'(0));
        if (exp_rsp.size() != 0) begin
          re = exp_rsp.pop_front();
          rsp_pops++;
          chk(rd_addr == re.addr, "rsp_rd_addr", CW'(rd_addr), CW'(re.addr));
          chk(rsp_data == re.data, "rsp_data", CW'(rsp_data), CW'(re.data));
          chk(rsp_last == re.last, "rsp_last", CW'(rsp_last), CW'(re.last));
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_rst   = rst;
    end
  end

  // Random backpressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) rsp_ready = ($urandom_range(0, 1) == 1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] v;
    int n;
    for (int a = 0; a < int'(DEPTH); a++) begin
      v = '0;
      for (int j = 0; j < 10; j++) v = (v << 32) | OUT_W'($urandom);
      mem[a] = v;
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_bank_mask = '0; cmd_wdata = '0; core_busy = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    // Directed writes: full fan-out, sparse mask, empty mask.
    do_write(9'h00A, 4'hF, WORD_W'(1), 1'b0);
    do_write(9'h00A, 4'b0101, rand_word(), 1'b0);
    do_write(9'h00A, 4'b0000, rand_word(), 1'b0);
    do_write(9'h1F0, 4'b1000, rand_word(), 1'b0);

    // Directed reads with random backpressure, including the address wrap.
    rand_ready = 1'b1;
    do_read(9'h010, 8'd11, 1'b0);
    do_read(9'h1FF, 8'd1, 1'b0);
    do_read(9'h0F0, 8'd0, 1'b0);
    do_read(9'h180, 8'd255, 1'b0);

    // core_busy blocks accepts, then releases within a cycle.
    core_busy = 1'b1;
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_addr = 9'h033; cmd_bank_mask = 4'b0110; cmd_wdata = WORD_W'(5);
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(cmd_ready == 1'b0, "busy_blocks", CW'(cmd_ready), CW'(0));
      chk(ext_en == 1'b0, "busy_no_write", CW'(ext_en), CW'(0));
    end
    @(posedge clk); #1 core_busy = 1'b0;
    @(negedge clk);
    chk(cmd_ready == 1'b1, "busy_release", CW'(cmd_ready), CW'(1));
    push_wr(9'h033, 4'b0110, WORD_W'(5));
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk(exp_wr.size() == 0, "busy_writes", CW'(exp_wr.size()), CW'(0));

    // core_busy rising mid-operation must not abort.
    do_write(9'h055, 4'b1011, rand_word(), 1'b1);
    do_read(9'h077, 8'd5, 1'b1);

    // Random command mix.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(ADDR_W'($urandom), N_BANK'($urandom), rand_word(), ($urandom_range(0, 3) == 0));
      else
        do_read(ADDR_W'($urandom), 8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    rand_ready = 1'b0;
    @(posedge clk); #2 rsp_ready = 1'b1;

    // Reset during the second write of a 4-bank load.
    push_wr(9'h021, 4'b0011, WORD_W'(9));
    send(1'b1, 9'h021, 8'd0, 4'hF, WORD_W'(9), 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk(ext_en == 1'b0, "rst_wr_abort", CW'(ext_en), CW'(0));
    end
    chk(exp_wr.size() == 0, "rst_wr_seen", CW'(exp_wr.size()), CW'(0));

    // Reset during word 3 of a read burst.
    rsp_pops = 0;
    send(1'b0, 9'h040, 8'd7, '0, '0, 1'b1);
    n = 0;
    while (rsp_pops < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(rsp_pops >= 2, "rst_rd_progress", CW'(rsp_pops), CW'(2));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_rsp.delete();
    @(negedge clk);
    chk_reset_vals();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk(rsp_valid == 1'b0 && ext_en == 1'b0, "rst_rd_abort", CW'({rsp_valid, ext_en}), CW'(0));
    end

    // A normal command after reset still works.
    do_write(9'h1FF, 4'b1100, rand_word(), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
